i2c_target_regs: RTL and testbench
==================================

I2C_TARGET_REGS -- requirements
Module: i2c_target_regs

Interface
REQ-001 SHALL have parameter DEVICE_ADDR, default 7'h71, meaning the 7-bit target address answered.
REQ-002 SHALL have parameter NUM_REGS, default 8, range 2..256, meaning the number of 8-bit registers addressable.
REQ-003 SHALL have parameter PTR_W, default $clog2(NUM_REGS), meaning the register pointer width.
REQ-004 Port system_clk  input  1  system clock; all logic on its rising edge; the only clock.
REQ-005 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-006 Port scl_in  input  1  raw SCL pin level, asynchronous.
REQ-007 Port sda_in  input  1  raw SDA pin level, asynchronous.
REQ-008 Port sda_oe  output  1  when 1, the pad pulls SDA low (open drain).
REQ-009 Port reg_wr_en  output  1  one-cycle register write strobe.
REQ-010 Port reg_addr  output  PTR_W  register pointer, used for both reads and writes.
REQ-011 Port reg_wr_data  output  8  write data; valid while reg_wr_en=1.
REQ-012 Port reg_rd_data  input  8  read data for reg_addr, combinational from the register file.
REQ-013 Port busy  output  1  high from an address-matched START until STOP.

Function
REQ-014 scl_in and sda_in SHALL each pass through a 2-flop synchroniser; all edges are detected on the synchronised values against a 1-cycle-delayed copy.
REQ-015 START/repeated START = SDA falling while SCL high; STOP = SDA rising while SCL high; both are detected in any state and take priority over bit sampling in the same cycle.
REQ-016 Bits SHALL be sampled on SCL rising; sda_oe SHALL change only on the cycle SCL falling is detected.
REQ-017 States: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
REQ-018 START -> ADDR with bit counter=0 from any state; STOP -> IDLE with sda_oe=0 from any state.
REQ-019 ADDR: after 8 bits, if addr[7:1]==DEVICE_ADDR -> ADDR_ACK with sda_oe=1 for the ninth clock; otherwise -> IGNORE with no ACK.
REQ-020 ADDR_ACK exit on the 9th SCL falling edge: for R/W=0 -> PTR; for R/W=1 -> RDATA, with the shift register loaded from reg_rd_data at the current pointer and MSB driven (sda_oe = ~bit).
REQ-021 PTR: the first written byte is the pointer; if <NUM_REGS, ACK and load the pointer -> PTR_ACK -> WDATA; otherwise NACK -> IGNORE, pointer unchanged.
REQ-022 WDATA: after 8 bits, pulse reg_wr_en for exactly 1 cycle with reg_addr=pointer, then ACK -> WDATA_ACK; the pointer increments after the strobe.
REQ-023 RDATA: the target drives 8 bits MSB first, then releases SDA -> RDATA_ACK; it samples the master bit on SCL rising.
REQ-024 RDATA_ACK: master ACK (0) -> pointer increment, reload, RDATA; master NACK (1) -> IGNORE.
REQ-025 Pointer increment SHALL wrap from NUM_REGS-1 to 0.
REQ-026 A repeated START after PTR_ACK SHALL keep the pointer (write-pointer-then-read sequence).
REQ-027 IGNORE: sda_oe=0; leave only on START or STOP.
REQ-028 The pointer SHALL persist across transactions until rewritten or reset.
REQ-029 busy SHALL set on an ADDR match and clear on STOP or on a non-matching address.

Reset
REQ-030 With rst_n=0, the state SHALL be IDLE immediately (asynchronously): sda_oe=0, reg_wr_en=0, reg_addr=0, reg_wr_data=0, busy=0, synchronisers=1, bit counter=0.
REQ-031 Reset mid-transaction SHALL abort without a write strobe; after release the block waits for a fresh START.

Configuration
REQ-032 With macro I2C_TARGET_GLITCH_FILTER_EN defined, each synchronised line SHALL pass a 3-sample majority filter, adding 2 cycles of latency; pulses of 1 cycle or less are rejected.
REQ-033 With I2C_TARGET_GLITCH_FILTER_EN undefined, the synchroniser output SHALL be used directly, with no filter logic present.

Verification
REQ-034 Write test: START, 0xE2, ptr 0x03, data 0xA5, STOP -> three ACKs; one reg_wr_en pulse with reg_addr=3 and reg_wr_data=0xA5; busy falls at STOP.
REQ-035 Read test: START, 0xE2, ptr 0x06, rSTART, 0xE3, read 3 bytes with ACK,ACK,NACK, regs 6,7,0 = 0x11,0x22,0x33 -> SDA carries 0x11,0x22,0x33; the pointer wraps 7->0.
REQ-036 Address mismatch: START, 0xAA, data 0x55, STOP -> sda_oe is never 1; no reg_wr_en; busy stays 0.
REQ-037 Bad pointer: START, 0xE2, ptr 0x08 (NUM_REGS=8) -> NACK on the pointer byte; following bytes ignored; no reg_wr_en.
REQ-038 rst_n pulsed low during the 4th bit of a data byte -> all outputs at reset values in the same cycle; no strobe; the next full transaction succeeds.
REQ-039 With I2C_TARGET_GLITCH_FILTER_EN defined, a 1-cycle SDA low glitch while SCL is high -> no START detected and the state stays IDLE; without the macro -> START detected.

Source files
------------

// File: rtl/i2c_target_regs.sv
// I2C target giving access to NUM_REGS 8-bit registers through an auto-incrementing pointer.
// Define I2C_TARGET_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL and SDA.
module i2c_target_regs #(
    parameter logic [6:0] DEVICE_ADDR = 7'h71,
    parameter int         NUM_REGS    = 8,
    parameter int         PTR_W       = $clog2(NUM_REGS)
) (
    input  logic             system_clk,
    input  logic             rst_n,
    input  logic             scl_in,
    input  logic             sda_in,
    output logic             sda_oe,
    output logic             reg_wr_en,
    output logic [PTR_W-1:0] reg_addr,
    output logic [7:0]       reg_wr_data,
    input  logic [7:0]       reg_rd_data,
    output logic             busy
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        PTR,
        PTR_ACK,
        WDATA,
        WDATA_ACK,
        RDATA,
        RDATA_ACK,
        IGNORE
    } state_t;

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_s;
    logic       sda_s;

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_in};
            sda_sync_q <= {sda_sync_q[0], sda_in};
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [1:0] scl_hist_q;
    logic [1:0] sda_hist_q;
    logic       scl_filt_q;
    logic       sda_filt_q;

    // A level is accepted only once two of the last three samples agree.
    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_hist_q <= 2'b11;
            sda_hist_q <= 2'b11;
            scl_filt_q <= 1'b1;
            sda_filt_q <= 1'b1;
        end else begin
            scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
            sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
            scl_filt_q <= (scl_sync_q[1] & scl_hist_q[0])
                        | (scl_sync_q[1] & scl_hist_q[1])
                        | (scl_hist_q[0] & scl_hist_q[1]);
            sda_filt_q <= (sda_sync_q[1] & sda_hist_q[0])
                        | (sda_sync_q[1] & sda_hist_q[1])
                        | (sda_hist_q[0] & sda_hist_q[1]);
        end
    end

    assign scl_s = scl_filt_q;
    assign sda_s = sda_filt_q;
`else
    assign scl_s = scl_sync_q[1];
    assign sda_s = sda_sync_q[1];
`endif

    logic       scl_d1_q;
    logic       sda_d1_q;
    logic       scl_rise;
    logic       scl_fall;
    logic       start_det;
    logic       stop_det;

    state_t     state_q,   state_d;
    logic [3:0] bitcnt_q,  bitcnt_d;
    logic [7:0] shift_q,   shift_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic       sda_oe_q,  sda_oe_d;
    logic       wr_en_q,   wr_en_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       busy_q,    busy_d;
    logic       mack_q,    mack_d;

    assign scl_rise  = scl_s & ~scl_d1_q;
    assign scl_fall  = ~scl_s & scl_d1_q;
    // SCL must be high on both samples so a data edge racing SCL low is not a condition.
    assign start_det = scl_s & scl_d1_q & ~sda_s & sda_d1_q;
    assign stop_det  = scl_s & scl_d1_q & sda_s & ~sda_d1_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_REGS - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        wr_en_d   = 1'b0;
        wr_data_d = wr_data_q;
        busy_d    = busy_q;
        mack_d    = mack_q;

        if (wr_en_q) begin
            ptr_d = ptr_inc(ptr_q);
        end

        if (stop_det) begin
            state_d  = IDLE;
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (start_det) begin
            state_d  = ADDR;
            bitcnt_d = '0;
            sda_oe_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    sda_oe_d = 1'b0;
                end
                ADDR: begin
                    if (scl_rise) begin
                        shift_d  = {shift_q[6:0], sda_s};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        bitcnt_d = '0;
                        if (shift_q[7:1] == DEVICE_ADDR) begin
                            state_d  = ADDR_ACK;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            state_d  = IGNORE;
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bitcnt_d = '0;
                        if (shift_q[0]) begin
                            state_d  = RDATA;
                            shift_d  = reg_rd_data;
                            sda_oe_d = ~reg_rd_data[7];
                        end else begin
                            state_d  = PTR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                PTR: begin
                    if (scl_rise) begin
                        shift_d  = {shift_q[6:0], sda_s};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        bitcnt_d = '0;
                        if ({1'b0, shift_q} < 9'(NUM_REGS)) begin
                            state_d  = PTR_ACK;
                            ptr_d    = shift_q[PTR_W-1:0];
                            sda_oe_d = 1'b1;
                        end else begin
                            state_d  = IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                PTR_ACK, WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d  = WDATA;
                        bitcnt_d = '0;
                        sda_oe_d = 1'b0;
                    end
                end
                WDATA: begin
                    if (scl_rise) begin
                        shift_d  = {shift_q[6:0], sda_s};
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        state_d   = WDATA_ACK;
                        bitcnt_d  = '0;
                        wr_en_d   = 1'b1;
                        wr_data_d = shift_q;
                        sda_oe_d  = 1'b1;
                    end
                end
                RDATA: begin
                    if (scl_rise) begin
                        bitcnt_d = bitcnt_q + 4'd1;
                    end else if (scl_fall && bitcnt_q == 4'd8) begin
                        state_d  = RDATA_ACK;
                        bitcnt_d = '0;
                        sda_oe_d = 1'b0;
                    end else if (scl_fall) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                RDATA_ACK: begin
                    // Advancing on the ACK rise lets reg_rd_data settle before the reload.
                    if (scl_rise) begin
                        mack_d = sda_s;
                        if (!sda_s) begin
                            ptr_d = ptr_inc(ptr_q);
                        end
                    end else if (scl_fall) begin
                        bitcnt_d = '0;
                        if (!mack_q) begin
                            state_d  = RDATA;
                            shift_d  = reg_rd_data;
                            sda_oe_d = ~reg_rd_data[7];
                        end else begin
                            state_d  = IGNORE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                IGNORE: begin
                    sda_oe_d = 1'b0;
                end
                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_d1_q  <= 1'b1;
            sda_d1_q  <= 1'b1;
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            mack_q    <= 1'b1;
        end else begin
            scl_d1_q  <= scl_s;
            sda_d1_q  <= sda_s;
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
            mack_q    <= mack_d;
        end
    end

    assign sda_oe      = sda_oe_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_addr    = ptr_q;
    assign reg_wr_data = wr_data_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master, register-file model,
// and scoreboards for ACK bits, read bytes and write strobes.
`timescale 1ns/1ps
module tb_i2c_target_regs;

    localparam int NUM_REGS = 8;
    localparam int PTR_W    = 3;
    localparam int T        = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             m_scl = 1'b1;
    logic             m_sda = 1'b1;
    logic             sda_line;
    logic             sda_oe;
    logic             reg_wr_en;
    logic [PTR_W-1:0] reg_addr;
    logic [7:0]       reg_wr_data;
    logic [7:0]       reg_rd_data;
    logic             busy;

    logic [7:0] regs [NUM_REGS];
    int checks = 0;
    int passes = 0;
    int wr_cnt = 0;
    logic oe_seen = 1'b0;
    logic busy_seen = 1'b0;

    logic [PTR_W+7:0] exp_wr_q [$];
    logic             exp_ack_q [$];
    logic [7:0]       exp_rd_q [$];

    always #5 clk = ~clk;

    assign sda_line    = m_sda & ~sda_oe;
    assign reg_rd_data = regs[reg_addr];

    i2c_target_regs #(
        .DEVICE_ADDR(7'h71),
        .NUM_REGS   (NUM_REGS)
    ) dut (
        .system_clk (clk),
        .rst_n      (rst_n),
        .scl_in     (m_scl),
        .sda_in     (sda_line),
        .sda_oe     (sda_oe),
        .reg_wr_en  (reg_wr_en),
        .reg_addr   (reg_addr),
        .reg_wr_data(reg_wr_data),
        .reg_rd_data(reg_rd_data),
        .busy       (busy)
    );

    always @(posedge clk) begin
        if (reg_wr_en === 1'b1) regs[reg_addr] <= reg_wr_data;
    end

    always @(negedge clk) begin
        logic [PTR_W+7:0] e;
        if (sda_oe === 1'b1) oe_seen = 1'b1;
        if (busy === 1'b1) busy_seen = 1'b1;
        if (reg_wr_en === 1'b1) begin
            wr_cnt++;
            checks++;
            if (exp_wr_q.size() == 0) begin
                $display("FAIL wr_strobe: got addr=%0d data=%h, want no strobe",
                         reg_addr, reg_wr_data);
            end else begin
                e = exp_wr_q.pop_front();
                if ({reg_addr, reg_wr_data} !== e)
                    $display("FAIL wr_strobe: got addr=%0d data=%h, want addr=%0d data=%h",
                             reg_addr, reg_wr_data, e[PTR_W+7:8], e[7:0]);
                else
                    passes++;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", passes, checks + 1);
        $fatal(1);
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clk_bit(input logic b, output logic r);
        m_sda = b;
        wait_cyc(T);
        m_scl = 1'b1;
        wait_cyc(T);
        r = sda_line;
        wait_cyc(T);
        m_scl = 1'b0;
        wait_cyc(T);
    endtask

    task automatic m_start();
        m_sda = 1'b1;
        wait_cyc(T);
        m_scl = 1'b1;
        wait_cyc(T);
        m_sda = 1'b0;
        wait_cyc(T);
        m_scl = 1'b0;
        wait_cyc(T);
    endtask

    task automatic m_stop();
        m_sda = 1'b0;
        wait_cyc(T);
        m_scl = 1'b1;
        wait_cyc(T);
        m_sda = 1'b1;
        wait_cyc(T);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) clk_bit(b[i], r);
        clk_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic r;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            clk_bit(1'b1, r);
            d = {d[6:0], r};
        end
        clk_bit(mack, r);
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sda_oe, reg_wr_en, busy} !== 3'b000)
            $display("FAIL reset_ctrl: got oe/wr/busy=%b, want 000", {sda_oe, reg_wr_en, busy});
        else passes++;
        checks++;
        if (reg_addr !== '0)
            $display("FAIL reset_addr: got %0d, want 0", reg_addr);
        else passes++;
        checks++;
        if (reg_wr_data !== 8'h00)
            $display("FAIL reset_wdata: got %h, want 00", reg_wr_data);
        else passes++;
        wait_cyc(4);
        @(negedge clk) rst_n = 1'b1;
        wait_cyc(10);
        checks++;
        if ({sda_oe, reg_wr_en, busy} !== 3'b000)
            $display("FAIL post_reset_idle: got oe/wr/busy=%b, want 000",
                     {sda_oe, reg_wr_en, busy});
        else passes++;
    endtask

    task automatic test_write();
        logic [7:0] b [3] = '{8'hE2, 8'h03, 8'hA5};
        logic ack, e;
        int w0 = wr_cnt;
        m_start();
        for (int i = 0; i < 3; i++) begin
            exp_ack_q.push_back(1'b0);
            if (i == 2) exp_wr_q.push_back({3'd3, 8'hA5});
            send_byte(b[i], ack);
            e = exp_ack_q.pop_front();
            checks++;
            if (ack !== e) $display("FAIL write_ack%0d: got %b, want %b", i, ack, e);
            else passes++;
        end
        checks++;
        if (busy !== 1'b1) $display("FAIL write_busy: got %b, want 1", busy);
        else passes++;
        m_stop();
        wait_cyc(4);
        checks++;
        if (busy !== 1'b0) $display("FAIL write_busy_stop: got %b, want 0", busy);
        else passes++;
        checks++;
        if (wr_cnt - w0 != 1 || exp_wr_q.size() != 0)
            $display("FAIL write_strobes: got %0d strobes, %0d pending, want 1 and 0",
                     wr_cnt - w0, exp_wr_q.size());
        else passes++;
        checks++;
        if (reg_addr !== 3'd4) $display("FAIL write_ptr_inc: got %0d, want 4", reg_addr);
        else passes++;
    endtask

    task automatic test_mismatch();
        logic [7:0] b [2] = '{8'hAA, 8'h55};
        logic ack, e;
        int w0 = wr_cnt;
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        m_start();
        for (int i = 0; i < 2; i++) begin
            exp_ack_q.push_back(1'b1);
            send_byte(b[i], ack);
            e = exp_ack_q.pop_front();
            checks++;
            if (ack !== e) $display("FAIL mismatch_ack%0d: got %b, want %b", i, ack, e);
            else passes++;
        end
        m_stop();
        wait_cyc(4);
        checks++;
        if (oe_seen !== 1'b0 || busy_seen !== 1'b0)
            $display("FAIL mismatch_quiet: got oe_seen=%b busy_seen=%b, want 0 0",
                     oe_seen, busy_seen);
        else passes++;
        checks++;
        if (wr_cnt != w0) $display("FAIL mismatch_strobe: got %0d, want 0", wr_cnt - w0);
        else passes++;
    endtask

    task automatic test_bad_ptr();
        logic [7:0] b [3] = '{8'hE2, 8'h08, 8'h77};
        logic       a [3] = '{1'b0, 1'b1, 1'b1};
        logic ack, e;
        int w0 = wr_cnt;
        m_start();
        for (int i = 0; i < 3; i++) begin
            exp_ack_q.push_back(a[i]);
            send_byte(b[i], ack);
            e = exp_ack_q.pop_front();
            checks++;
            if (ack !== e) $display("FAIL badptr_ack%0d: got %b, want %b", i, ack, e);
            else passes++;
        end
        m_stop();
        wait_cyc(4);
        checks++;
        if (wr_cnt != w0) $display("FAIL badptr_strobe: got %0d, want 0", wr_cnt - w0);
        else passes++;
        checks++;
        if (reg_addr !== 3'd4) $display("FAIL badptr_keep: got %0d, want 4", reg_addr);
        else passes++;
    endtask

    task automatic test_write_wrap();
        logic [7:0] b [5] = '{8'hE2, 8'h06, 8'h11, 8'h22, 8'h33};
        logic [2:0] ad [5] = '{3'd0, 3'd0, 3'd6, 3'd7, 3'd0};
        logic ack, e;
        m_start();
        for (int i = 0; i < 5; i++) begin
            exp_ack_q.push_back(1'b0);
            if (i >= 2) exp_wr_q.push_back({ad[i], b[i]});
            send_byte(b[i], ack);
            e = exp_ack_q.pop_front();
            checks++;
            if (ack !== e) $display("FAIL wrap_ack%0d: got %b, want %b", i, ack, e);
            else passes++;
        end
        m_stop();
        wait_cyc(4);
        checks++;
        if (exp_wr_q.size() != 0) $display("FAIL wrap_pending: got %0d, want 0", exp_wr_q.size());
        else passes++;
        checks++;
        if (reg_addr !== 3'd1) $display("FAIL wrap_ptr: got %0d, want 1", reg_addr);
        else passes++;
    endtask

    task automatic test_read();
        logic [7:0] rd [3] = '{8'h11, 8'h22, 8'h33};
        logic       mk [3] = '{1'b0, 1'b0, 1'b1};
        logic [7:0] d, ed;
        logic ack, e;
        m_start();
        exp_ack_q.push_back(1'b0);
        send_byte(8'hE2, ack);
        exp_ack_q.push_back(1'b0);
        send_byte(8'h06, ack);
        e = exp_ack_q.pop_front();
        checks++;
        if (ack !== 1'b0 || e !== 1'b0) $display("FAIL read_ptr_ack: got %b, want 0", ack);
        else passes++;
        exp_ack_q.delete();
        m_start();
        exp_ack_q.push_back(1'b0);
        send_byte(8'hE3, ack);
        e = exp_ack_q.pop_front();
        checks++;
        if (ack !== e) $display("FAIL read_addr_ack: got %b, want %b", ack, e);
        else passes++;
        for (int i = 0; i < 3; i++) exp_rd_q.push_back(rd[i]);
        for (int i = 0; i < 3; i++) begin
            read_byte(mk[i], d);
            ed = exp_rd_q.pop_front();
            checks++;
            if (d !== ed) $display("FAIL read_byte%0d: got %h, want %h", i, d, ed);
            else passes++;
        end
        m_stop();
        wait_cyc(4);
        checks++;
        if (reg_addr !== 3'd0 || sda_oe !== 1'b0 || busy !== 1'b0)
            $display("FAIL read_end: got ptr=%0d oe=%b busy=%b, want 0 0 0",
                     reg_addr, sda_oe, busy);
        else passes++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] b [3] = '{8'hE2, 8'h05, 8'h3C};
        logic ack, e, r;
        int w0;
        m_start();
        send_byte(8'hE2, ack);
        send_byte(8'h02, ack);
        w0 = wr_cnt;
        clk_bit(1'b0, r);
        clk_bit(1'b1, r);
        clk_bit(1'b0, r);
        m_sda = 1'b1;
        wait_cyc(T);
        m_scl = 1'b1;
        wait_cyc(T / 2);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sda_oe, reg_wr_en, busy} !== 3'b000 || reg_addr !== '0 || reg_wr_data !== 8'h00)
            $display("FAIL midreset_outs: got oe/wr/busy=%b addr=%0d wdata=%h, want 000 0 00",
                     {sda_oe, reg_wr_en, busy}, reg_addr, reg_wr_data);
        else passes++;
        wait_cyc(3);
        @(negedge clk) rst_n = 1'b1;
        m_scl = 1'b0;
        wait_cyc(T);
        m_scl = 1'b1;
        wait_cyc(2 * T);
        checks++;
        if (wr_cnt != w0) $display("FAIL midreset_strobe: got %0d, want 0", wr_cnt - w0);
        else passes++;
        m_start();
        for (int i = 0; i < 3; i++) begin
            exp_ack_q.push_back(1'b0);
            if (i == 2) exp_wr_q.push_back({3'd5, 8'h3C});
            send_byte(b[i], ack);
            e = exp_ack_q.pop_front();
            checks++;
            if (ack !== e) $display("FAIL midreset_ack%0d: got %b, want %b", i, ack, e);
            else passes++;
        end
        m_stop();
        wait_cyc(4);
        checks++;
        if (exp_wr_q.size() != 0 || regs[5] !== 8'h3C)
            $display("FAIL midreset_recover: got pending=%0d reg5=%h, want 0 3c",
                     exp_wr_q.size(), regs[5]);
        else passes++;
    endtask

    task automatic test_glitch();
        logic ack, e, eb;
        logic r;
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        e  = 1'b1;
        eb = 1'b0;
`else
        e  = 1'b0;
        eb = 1'b1;
`endif
        wait_cyc(2 * T);
        @(negedge clk) m_sda = 1'b0;
        @(negedge clk) begin
            m_sda = 1'b1;
            m_scl = 1'b0;
        end
        wait_cyc(T);
        exp_ack_q.push_back(e);
        for (int i = 7; i >= 0; i--) clk_bit(i == 7 || i == 6 || i == 5 || i == 1, r);
        clk_bit(1'b1, ack);
        e = exp_ack_q.pop_front();
        checks++;
        if (ack !== e) $display("FAIL glitch_ack: got %b, want %b", ack, e);
        else passes++;
        checks++;
        if (busy !== eb) $display("FAIL glitch_busy: got %b, want %b", busy, eb);
        else passes++;
        m_stop();
        wait_cyc(4);
        checks++;
        if (busy !== 1'b0) $display("FAIL glitch_stop: got %b, want 0", busy);
        else passes++;
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) regs[i] = 8'h00;
        test_reset();
        test_write();
        test_mismatch();
        test_bad_ptr();
        test_write_wrap();
        test_read();
        test_reset_mid();
        test_glitch();
        wait_cyc(10);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
